// File: rtl/traffic_phase_arbiter.sv
// Purpose : four-approach traffic phase sequencer (ALLRED/GREEN/YELLOW/EMG) with
//           round-robin service, green extension, pedestrian latches and preemption.
// Latency : one clk from decision to registered state; lamps decode with zero latency.
// Backpressure: none; demands are levels, buttons are latched until served.
//
// Ports:
//   clk, reset (sync, active-low), tick (timebase pulse)
//   veh_req[3:0] vehicle demand levels, ped_btn[3:0] pedestrian button pulses
//   emg_req / emg_dir[1:0] emergency preemption request and target approach
//   green/yellow/red/walk[3:0] per-approach drives, cur[1:0] served approach,
//   state[1:0] FSM code (ALLRED=00, GREEN=01, YELLOW=10, EMG=11)
module traffic_phase_arbiter #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] veh_req,
    input  logic [3:0] ped_btn,
    input  logic       emg_req,
    input  logic [1:0] emg_dir,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [3:0] walk,
    output logic [1:0] cur,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_EMG    = 2'b11
    } state_e;

    localparam logic [5:0] GMIN_W = 6'(GREEN_MIN);
    localparam logic [5:0] GMAX_W = 6'(GREEN_MAX);
    localparam logic [5:0] YEL_W  = 6'(YELLOW_T);
    localparam logic [5:0] AR_W   = 6'(ALLRED_T);

    state_e     state_q, state_d;
    logic [4:0] timer_q, timer_d;
    logic [1:0] cur_q,   cur_d;
    logic [3:0] ped_pend_q, ped_pend_d;

    logic [3:0] pending;
    logic [3:0] others;
    logic [3:0] cur_oh;
    logic [3:0] ped_clr;
    logic [5:0] timer_inc;
    logic       gmin_exp, gmax_exp, yel_exp, ar_exp;
    logic [1:0] rr_idx;
    logic [1:0] rr_cand;
    logic       rr_found;

    assign cur_oh    = 4'b0001 << cur_q;
    assign pending   = veh_req | ped_pend_q;
    assign others    = pending & ~cur_oh;
    // One bit wider so the comparison still works when the timer sits at 31.
    assign timer_inc = {1'b0, timer_q} + 6'd1;
    assign gmin_exp  = tick & (timer_inc >= GMIN_W);
    assign gmax_exp  = tick & (timer_inc >= GMAX_W);
    assign yel_exp   = tick & (timer_inc >= YEL_W);
    assign ar_exp    = tick & (timer_inc >= AR_W);

    // Round-robin search starting after the last served approach; cur itself last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = cur_q;
        rr_cand  = cur_q;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = cur_q + 2'(k);
            if (!rr_found && pending[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ped_clr = 4'b0000;
        case (state_q)
            ST_ALLRED: begin
                if (ar_exp && emg_req) begin
                    state_d = ST_EMG;
                    cur_d   = emg_dir;
                end else if (ar_exp && rr_found) begin
                    state_d = ST_GREEN;
                    cur_d   = rr_idx;
                end
            end
            ST_GREEN: begin
                // Preemption acts on the next edge, regardless of tick or GREEN_MIN.
                if (emg_req) begin
                    state_d = (emg_dir == cur_q) ? ST_EMG : ST_YELLOW;
                end else if (others != 4'b0000) begin
                    if ((gmin_exp && !veh_req[cur_q]) || gmax_exp) begin
                        state_d = ST_YELLOW;
                    end
                end
                if (gmin_exp || (state_d != ST_GREEN)) begin
                    ped_clr = cur_oh;
                end
            end
            ST_YELLOW: begin
                if (yel_exp) begin
                    state_d = ST_ALLRED;
                end
            end
            ST_EMG: begin
                if (!emg_req) begin
                    state_d = ST_YELLOW;
                end
            end
            default: state_d = ST_ALLRED;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = 5'd0;
        end else if (tick && (timer_q != 5'd31)) begin
            timer_d = timer_q + 5'd1;
        end
    end

    // A new press wins over a same-cycle clear so it is never lost.
    assign ped_pend_d = (ped_pend_q & ~ped_clr) | ped_btn;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_ALLRED;
            timer_q    <= 5'd0;
            cur_q      <= 2'd3;
            ped_pend_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cur_q      <= cur_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        green  = 4'b0000;
        yellow = 4'b0000;
        walk   = 4'b0000;
        case (state_q)
            ST_GREEN: begin
                green = cur_oh;
                walk  = cur_oh & ped_pend_q;
            end
            ST_EMG:    green  = cur_oh;
            ST_YELLOW: yellow = cur_oh;
            default: ;
        endcase
    end

    assign red   = ~(green | yellow);
    assign cur   = cur_q;
    assign state = state_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
module tb_traffic_phase_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] veh_req = 4'b0000;
    logic [3:0] ped_btn = 4'b0000;
    logic       emg_req = 1'b0;
    logic [1:0] emg_dir = 2'd0;
    logic [3:0] green, yellow, red, walk;
    logic [1:0] cur, state;

    traffic_phase_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .veh_req (veh_req),
        .ped_btn (ped_btn),
        .emg_req (emg_req),
        .emg_dir (emg_dir),
        .green   (green),
        .yellow  (yellow),
        .red     (red),
        .walk    (walk),
        .cur     (cur),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Duration modes: exact tick count, at-least tick count, or not checked.
    localparam int EXACT = 0;
    localparam int ATLEAST = 1;
    localparam int DC = 2;

    typedef struct {
        logic [21:0] tup;
        int          mode;
        int          dur;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string name, input logic [1:0] st, input logic [1:0] c,
                        input logic [3:0] g, input logic [3:0] y, input logic [3:0] r,
                        input logic [3:0] w, input int mode, input int dur);
        exp_t e;
        e.tup  = {st, c, g, y, r, w};
        e.mode = mode;
        e.dur  = dur;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset for two clks; the next scenario's demand is applied while reset is low.
    task automatic do_reset(input string name, input logic [3:0] next_veh);
        push(name, 2'b00, 2'd3, 4'b0000, 4'b0000, 4'b1111, 4'b0000, DC, 0);
        reset   = 1'b0;
        emg_req = 1'b0;
        veh_req = next_veh;
        clks(2);
        reset = 1'b1;
    endtask

    // Free-running timebase: one clk high out of every four.
    int tick_cnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick     = (tick_cnt == 3);
            tick_cnt = (tick_cnt + 1) % 4;
        end
    end

    // Monitor: each change of the observed lamp/state tuple pops one expected
    // entry; the tick count of the segment that just ended is checked as well.
    initial begin
        logic [21:0] prev_tup;
        logic [21:0] now_tup;
        exp_t        seg;
        bit          have_seg;
        int          seg_ticks;
        prev_tup  = 'x;
        have_seg  = 0;
        seg_ticks = 0;
        forever begin
            @(negedge clk);
            now_tup = {state, cur, green, yellow, red, walk};
            if (now_tup !== prev_tup) begin
                if (have_seg && seg.mode != DC) begin
                    checks++;
                    if ((seg.mode == EXACT && seg_ticks != seg.dur) ||
                        (seg.mode == ATLEAST && seg_ticks < seg.dur)) begin
                        errors++;
                        $display("FAIL %s duration: got %0d ticks, required %s%0d", seg.name,
                                 seg_ticks, (seg.mode == ATLEAST) ? ">=" : "", seg.dur);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    have_seg = 0;
                    $display("FAIL unexpected_change: got st=%b cur=%0d g=%b y=%b r=%b w=%b",
                             state, cur, green, yellow, red, walk);
                end else begin
                    seg      = exp_q.pop_front();
                    have_seg = 1;
                    if (now_tup !== seg.tup) begin
                        errors++;
                        $display("FAIL %s: got st=%b cur=%0d g=%b y=%b r=%b w=%b, required st=%b cur=%0d g=%b y=%b r=%b w=%b",
                                 seg.name, state, cur, green, yellow, red, walk,
                                 seg.tup[21:20], seg.tup[19:18], seg.tup[17:14],
                                 seg.tup[13:10], seg.tup[9:6], seg.tup[5:2]);
                    end
                end
                seg_ticks = 0;
                prev_tup  = now_tup;
            end
            if (tick) seg_ticks++;
            // Lamp exclusivity: one lamp per approach, at most one approach non-red.
            checks++;
            if (((green & yellow) | (green & red) | (yellow & red)) != 4'b0000 ||
                (green | yellow | red) != 4'b1111 || $countones(~red) > 1) begin
                errors++;
                $display("FAIL lamp_exclusive: got g=%b y=%b r=%b", green, yellow, red);
            end
        end
    end

    initial begin
        logic [3:0] oh;
        // Reset state, then a single demand that rests in green.
        push("reset_initial", 2'b00, 2'd3, 4'b0000, 4'b0000, 4'b1111, 4'b0000, DC, 0);
        clks(3);
        reset = 1'b1;
        clks(5);
        push("single_green0", 2'b01, 2'd0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, ATLEAST, 100);
        veh_req = 4'b0001;
        clks(420);

        // Reset while green, then extension to GREEN_MAX with approaches 0 and 1.
        do_reset("reset_in_green", 4'b0011);
        push("ext_green0",  2'b01, 2'd0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, EXACT, 12);
        push("ext_yellow0", 2'b10, 2'd0, 4'b0000, 4'b0001, 4'b1110, 4'b0000, EXACT, 2);
        push("ext_allred0", 2'b00, 2'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, EXACT, 1);
        push("ext_green1",  2'b01, 2'd1, 4'b0010, 4'b0000, 4'b1101, 4'b0000, DC, 0);
        clks(100);
        veh_req = 4'b0000;
        clks(8);

        // Pedestrian only: walk for GREEN_MIN ticks, then rest in green.
        do_reset("reset_b", 4'b0000);
        push("ped_walk2", 2'b01, 2'd2, 4'b0100, 4'b0000, 4'b1011, 4'b0100, EXACT, 4);
        push("ped_rest2", 2'b01, 2'd2, 4'b0100, 4'b0000, 4'b1011, 4'b0000, DC, 0);
        ped_btn = 4'b0100;
        clks(1);
        ped_btn = 4'b0000;
        clks(40);

        // Green ends at GREEN_MIN when its own demand is absent and another waits.
        do_reset("reset_c", 4'b0000);
        push("min_green0",  2'b01, 2'd0, 4'b0001, 4'b0000, 4'b1110, 4'b0001, EXACT, 4);
        push("min_yellow0", 2'b10, 2'd0, 4'b0000, 4'b0001, 4'b1110, 4'b0000, EXACT, 2);
        push("min_allred0", 2'b00, 2'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, EXACT, 1);
        push("min_green1",  2'b01, 2'd1, 4'b0010, 4'b0000, 4'b1101, 4'b0000, DC, 0);
        ped_btn = 4'b0001;
        clks(1);
        ped_btn = 4'b0000;
        veh_req = 4'b0010;
        clks(50);

        // Preemption to approach 2 from green 0, then direct EMG on own approach.
        do_reset("reset_f", 4'b0001);
        push("emg_green0",  2'b01, 2'd0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, DC, 0);
        push("emg_yellow0", 2'b10, 2'd0, 4'b0000, 4'b0001, 4'b1110, 4'b0000, EXACT, 2);
        push("emg_allred0", 2'b00, 2'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, EXACT, 1);
        push("emg_hold2",   2'b11, 2'd2, 4'b0100, 4'b0000, 4'b1011, 4'b0000, DC, 0);
        push("emg_yellow2", 2'b10, 2'd2, 4'b0000, 4'b0100, 4'b1011, 4'b0000, EXACT, 2);
        push("emg_allred2", 2'b00, 2'd2, 4'b0000, 4'b0000, 4'b1111, 4'b0000, EXACT, 1);
        push("emg_regreen", 2'b01, 2'd0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, DC, 0);
        push("emg_direct0", 2'b11, 2'd0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, DC, 0);
        clks(20);
        emg_dir = 2'd2;
        emg_req = 1'b1;
        clks(30);
        emg_dir = 2'd1;
        clks(10);
        emg_req = 1'b0;
        clks(40);
        emg_dir = 2'd0;
        emg_req = 1'b1;
        clks(10);

        // Reset mid-EMG, then full round-robin with constant demand on all four.
        do_reset("reset_mid_emg", 4'b1111);
        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << i;
            push($sformatf("rr_green%0d", i),  2'b01, 2'(i), oh, 4'b0000, ~oh, 4'b0000, EXACT, 12);
            push($sformatf("rr_yellow%0d", i), 2'b10, 2'(i), 4'b0000, oh, ~oh, 4'b0000, EXACT, 2);
            push($sformatf("rr_allred%0d", i), 2'b00, 2'(i), 4'b0000, 4'b0000, 4'b1111, 4'b0000, EXACT, 1);
        end
        push("rr_green0_again", 2'b01, 2'd0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, DC, 0);
        clks(270);

        do_reset("reset_final", 4'b0000);
        clks(10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d left, required 0 (next %s)",
                     exp_q.size(), exp_q[0].name);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_arbiter.md
TRAFFIC_PHASE_ARBITER -- requirements
Module: traffic_phase_arbiter

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green time in ticks; legal range 1..31.
REQ-002 Parameter GREEN_MAX, default 12: maximum extended green time in ticks; GREEN_MIN <= GREEN_MAX <= 31.
REQ-003 Parameter YELLOW_T, default 2: yellow duration in ticks; legal range 1..31.
REQ-004 Parameter ALLRED_T, default 1: all-red clearance duration in ticks; legal range 1..31.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 Port tick, input, 1 bit: one-clk timebase pulse; all durations are counted in ticks.
REQ-008 Port veh_req, input, 4 bits: level vehicle demand, one bit per approach 0..3.
REQ-009 Port ped_btn, input, 4 bits: pedestrian button pulses, one bit per approach.
REQ-010 Port emg_req, input, 1 bit: level emergency preemption request.
REQ-011 Port emg_dir, input, 2 bits: approach index to preempt to.
REQ-012 Ports green, yellow, red, output, 4 bits each: per-approach lamp drives.
REQ-013 Port walk, output, 4 bits: per-approach pedestrian walk signal.
REQ-014 Port cur, output, 2 bits: index of the approach currently served.
REQ-015 Port state, output, 2 bits: FSM state code (ALLRED=00, GREEN=01, YELLOW=10, EMG=11).

Function
REQ-016 A 5-bit timer shall clear on every state change.
REQ-017 On each tick that does not cause a transition, the timer shall increment, saturating at 31; timer value = ticks elapsed in the current state.
REQ-018 A duration N shall expire on the tick cycle where timer+1 >= N; the transition takes effect on that clk edge.
REQ-019 Each ped_pend[i] latch shall set on ped_btn[i]=1; the set shall take priority over a same-cycle clear.
REQ-020 pending[i] = veh_req[i] | ped_pend[i]; others = pending with bit cur masked.
REQ-021 ALLRED: when ALLRED_T expires and emg_req=1, go to EMG and set cur<=emg_dir.
REQ-022 ALLRED: else when ALLRED_T expires and pending!=0, go to GREEN with cur<= the first pending index searched cur+1, cur+2, cur+3, cur (mod 4).
REQ-023 ALLRED: else remain in ALLRED, with timer saturated; re-evaluate on every later tick.
REQ-024 GREEN: emg_req=1 with emg_dir==cur goes to EMG on the next edge, independent of tick.
REQ-025 GREEN: emg_req=1 with emg_dir!=cur goes to YELLOW on the next edge, ignoring GREEN_MIN.
REQ-026 GREEN: when GREEN_MIN expires with others!=0 and veh_req[cur]=0, go to YELLOW.
REQ-027 GREEN: when GREEN_MAX expires with others!=0, go to YELLOW regardless of veh_req[cur].
REQ-028 GREEN: with others==0, hold green indefinitely (rest in green).
REQ-029 GREEN: ped_pend[cur] shall clear on the tick where GREEN_MIN expires, or on exit from GREEN, whichever is first.
REQ-030 YELLOW: when YELLOW_T expires, go to ALLRED; emg_req has no effect in YELLOW.
REQ-031 EMG: cur holds the value latched at entry; emg_dir changes are ignored while in EMG.
REQ-032 EMG: on emg_req=0, go to YELLOW on the next edge, with cur unchanged.
REQ-033 Lamp outputs shall decode combinationally from registered state/cur with zero latency: green[cur]=1 in GREEN and EMG; yellow[cur]=1 in YELLOW; red = ~(green|yellow).
REQ-034 Exactly one of green/yellow/red shall be 1 per approach at all times; at most one approach shall be non-red.
REQ-035 walk[i] = (state==GREEN) & (cur==i) & ped_pend[i]; walk shall be 0 in EMG.

Reset
REQ-036 When reset=0 at a clk edge: state<=ALLRED, timer<=0, cur<=3, ped_pend<=0; this overrides any in-flight operation, including mid-EMG.
REQ-037 During and after reset: red=1111, green=0000, yellow=0000, walk=0000, state=00.

Verification
REQ-038 Reset test: reset=0 for 2 clks while in GREEN -> next edge red=1111, green=0000, state=00, cur=3.
REQ-039 Single demand: veh_req=0001, tick every 4 clks, defaults -> green=0001 after 1 tick; held for 100 ticks with no yellow.
REQ-040 Extension: veh_req=0011 held -> green[0] lasts 12 ticks, yellow[0] 2 ticks, all-red 1 tick, then green[1].
REQ-041 Pedestrian: ped_btn=0100 pulse, veh_req=0 -> green=0100 with walk=0100 for exactly 4 ticks, then walk=0 while green stays.
REQ-042 Preemption: in GREEN cur=0, emg_req=1, emg_dir=2 -> next edge yellow=0001; 2 ticks; all-red 1 tick; green=0100, state=11; after emg_req=0 -> yellow=0100.
REQ-043 Fairness: veh_req=1111 constant from reset -> green order 0,1,2,3,0, each 12 ticks; lamp exclusivity assertion (REQ-034) never fires.
